// File: rtl/simpleadder_driver.sv
// Requester-side driver for simpleadder: one request in, operands driven for ALU_LATENCY edges, one response out.
// Define SIMPLEADDER_DRIVER_CHECK_EN to add an internal reference result and the rsp_mismatch output.
module simpleadder_driver #(
    parameter int LENGTH      = 16,
    parameter int ALU_LATENCY = 2,
    parameter int CNT_W       = 8
) (
    input  logic              sig_clock,
    input  logic              sig_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [LENGTH-1:0] req_ina,
    input  logic [LENGTH-1:0] req_inb,
    output logic [1:0]        operation,
    output logic [LENGTH-1:0] sig_ina,
    output logic [LENGTH-1:0] sig_inb,
    input  logic [LENGTH:0]   sig_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_op,
    output logic [LENGTH:0]   rsp_data,
    output logic              rsp_illegal,
    output logic [CNT_W-1:0]  txn_count,
    output logic [1:0]        dbg_state
`ifdef SIMPLEADDER_DRIVER_CHECK_EN
    ,
    output logic              rsp_mismatch
`endif
);

    // Both ports are valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; a raised valid holds its payload unchanged until that edge.

    localparam int WCNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                req_ready_d;
    logic [1:0]          operation_d;
    logic [LENGTH-1:0]   sig_ina_d, sig_inb_d;
    logic                rsp_valid_d;
    logic [1:0]          rsp_op_d;
    logic [LENGTH:0]     rsp_data_d;
    logic                rsp_illegal_d;
    logic [CNT_W-1:0]    txn_count_d;
`ifdef SIMPLEADDER_DRIVER_CHECK_EN
    logic                rsp_mismatch_d;
    logic [LENGTH:0]     exp_result;

    // Reference result from the operands currently held on the adder inputs.
    always_comb begin
        if (operation == OP_ADD) begin
            exp_result = {1'b0, sig_ina} + {1'b0, sig_inb};
        end else begin
            exp_result = {1'b0, sig_ina} - {1'b0, sig_inb};
        end
    end
`endif

    assign dbg_state = state_q;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        operation_d   = operation;
        sig_ina_d     = sig_ina;
        sig_inb_d     = sig_inb;
        rsp_valid_d   = rsp_valid;
        rsp_op_d      = rsp_op;
        rsp_data_d    = rsp_data;
        rsp_illegal_d = rsp_illegal;
        txn_count_d   = txn_count;
`ifdef SIMPLEADDER_DRIVER_CHECK_EN
        rsp_mismatch_d = rsp_mismatch;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    rsp_op_d = req_op;
                    if (req_op == OP_ADD || req_op == OP_SUB) begin
                        operation_d = req_op;
                        sig_ina_d   = req_ina;
                        sig_inb_d   = req_inb;
                        wait_cnt_d  = WCNT_W'(ALU_LATENCY);
                        state_d     = WAIT;
                    end else begin
                        // Illegal ops never reach the adder and are answered immediately.
                        operation_d   = OP_NOP;
                        rsp_data_d    = '0;
                        rsp_illegal_d = 1'b1;
                        rsp_valid_d   = 1'b1;
`ifdef SIMPLEADDER_DRIVER_CHECK_EN
                        rsp_mismatch_d = 1'b0;
`endif
                        state_d       = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    rsp_data_d  = sig_out;
                    rsp_valid_d = 1'b1;
                    operation_d = OP_NOP;
`ifdef SIMPLEADDER_DRIVER_CHECK_EN
                    rsp_mismatch_d = (sig_out !== exp_result);
`endif
                    state_d     = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - WCNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_illegal_d = 1'b0;
`ifdef SIMPLEADDER_DRIVER_CHECK_EN
                    rsp_mismatch_d = 1'b0;
`endif
                    txn_count_d   = txn_count + CNT_W'(1);
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered ready: the edge that returns to IDLE cannot also accept a request.
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge sig_clock or negedge sig_rst) begin
        if (!sig_rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            req_ready   <= 1'b0;
            operation   <= OP_NOP;
            sig_ina     <= '0;
            sig_inb     <= '0;
            rsp_valid   <= 1'b0;
            rsp_op      <= '0;
            rsp_data    <= '0;
            rsp_illegal <= 1'b0;
            txn_count   <= '0;
`ifdef SIMPLEADDER_DRIVER_CHECK_EN
            rsp_mismatch <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            req_ready   <= req_ready_d;
            operation   <= operation_d;
            sig_ina     <= sig_ina_d;
            sig_inb     <= sig_inb_d;
            rsp_valid   <= rsp_valid_d;
            rsp_op      <= rsp_op_d;
            rsp_data    <= rsp_data_d;
            rsp_illegal <= rsp_illegal_d;
            txn_count   <= txn_count_d;
`ifdef SIMPLEADDER_DRIVER_CHECK_EN
            rsp_mismatch <= rsp_mismatch_d;
`endif
        end
    end

endmodule

// File: doc/simpleadder_driver.md
Name: simpleadder_driver

Overview:
- Requester side of the simpleadder interface: accepts one arithmetic request on a valid/ready port, drives the operation and operand lines toward simpleadder, and waits the adder's fixed pipeline latency.
- It then captures sig_out and returns the result on a valid/ready response port.
- One transaction in flight at a time; sits between the test/sequence logic and the simpleadder instance.

Parameters:
- LENGTH, 16, operand width; result width is LENGTH+1.
- ALU_LATENCY, 2, clock edges from operation/operands stable to a valid sig_out (minimum 1).
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- sig_clock  in  1  single clock, rising edge.
- sig_rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request.
- req_op  in  2  01 = subtract, 10 = add, 00/11 = illegal.
- req_ina  in  LENGTH  operand A.
- req_inb  in  LENGTH  operand B.
- operation  out  2  to simpleadder operation.
- sig_ina  out  LENGTH  to simpleadder sig_ina.
- sig_inb  out  LENGTH  to simpleadder sig_inb.
- sig_out  in  LENGTH+1  result from simpleadder.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_op  out  2  echo of the request op.
- rsp_data  out  LENGTH+1  captured result.
- rsp_illegal  out  1  request op was 00 or 11.
- txn_count  out  CNT_W  count of completed response handshakes.

Behaviour:
- Reset (sig_rst low, asynchronous):
  - State goes to IDLE.
  - operation = 00; sig_ina, sig_inb, rsp_data, rsp_op and txn_count = 0.
  - rsp_valid = 0, rsp_illegal = 0, req_ready = 1 one cycle after release.
- Outputs: all outputs are registered; req_ready is high only in IDLE.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with req_valid && req_ready, latch op and operands.
  - Legal op: drive operation/sig_ina/sig_inb from the latched values; load the wait counter with ALU_LATENCY; go to WAIT.
  - Illegal op: operation stays 00; rsp_data = 0; rsp_illegal = 1; rsp_valid = 1; go to RESP on the same edge.
- WAIT:
  - operation and operands held stable every cycle.
  - Counter decrements each edge.
  - On the edge where the counter reads 0, sample sig_out into rsp_data, set rsp_valid = 1, return operation to 00, go to RESP.
  - Legal request accepted at edge A: sig_out is sampled at edge A+ALU_LATENCY+1 and rsp_valid is high after that edge (default: 3 cycles).
- RESP:
  - rsp_valid, rsp_data, rsp_op and rsp_illegal held until an edge with rsp_ready high.
  - On that edge: clear rsp_valid and rsp_illegal, increment txn_count (wraps to 0 at 2^CNT_W-1), return to IDLE.
  - No new request is accepted on the same edge; next acceptance is possible one cycle later.
- sig_out value: taken as-is, with no sign interpretation; subtraction borrow wraps modulo 2^(LENGTH+1).
- X/Z on sig_out outside the sample edge is ignored.
- Request-side inputs: changes while req_ready is low are ignored.
- Reset asserted mid-WAIT or mid-RESP: the transaction is dropped, nothing is reported, and txn_count clears.

Optional Feature:
- Macro: SIMPLEADDER_DRIVER_CHECK_EN.
- Defined:
  - The driver computes the expected result internally: A+B or A-B, LENGTH+1 bits, modulo 2^(LENGTH+1).
  - Extra output port rsp_mismatch (1 bit), registered with rsp_data, is high when the sampled sig_out differs from the expected value or contains X.
  - rsp_mismatch is forced 0 for illegal ops and cleared with rsp_valid; reset value 0.
- Undefined: no port, no comparator logic.

Test Plan:
- Add: req_op = 10, A = 0x0005, B = 0x0003 accepted at edge 0 → operation = 10 from edge 0 to edge 3; rsp_valid after edge 3 with rsp_data = 0x00008, rsp_op = 10, rsp_illegal = 0.
- Subtract: req_op = 01, A = 0x0005, B = 0x0007 → rsp_data = 0x1FFFE; add A = B = 0xFFFF → rsp_data = 0x1FFFE.
- Illegal: req_op = 11 → operation never leaves 00; rsp_valid after 1 edge with rsp_illegal = 1, rsp_data = 0; req_ready low until the response handshake.
- Backpressure: hold rsp_ready low for 5 cycles → rsp_valid/rsp_data stable and req_ready = 0 throughout; txn_count increments by exactly 1 on release; 256 transactions with CNT_W = 8 → txn_count wraps to 0.
- Reset: pull sig_rst low during WAIT → immediately operation = 00, rsp_valid = 0, txn_count = 0; after release req_ready = 1 and a new add completes correctly.
- With SIMPLEADDER_DRIVER_CHECK_EN: force sig_out to 0x00009 for add 5+3 → rsp_mismatch = 1; correct value → rsp_mismatch = 0.
